// File: rtl/cmd_pkg.sv
// Shared opcode/reply byte values and the command FSM state type for the
// UART-to-SPI command bridge.
package cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
    localparam logic [7:0] OP_RESET = 8'h72;  // 'r'
    localparam logic [7:0] OP_PING  = 8'h70;  // 'p'

    localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_UNK     = 8'h3F;  // '?'
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T'
    localparam logic [7:0] RSP_SPIERR  = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_SPI_ISSUE,
        ST_SPI_WAIT,
        ST_RST_HOLD,
        ST_REPLY,
        ST_REPLY_WAIT
    } state_t;

endpackage

// File: rtl/cmd_timeout_counter.sv
// Up-counter with synchronous clear/load and a terminal-count compare; the
// bridge shares one instance for byte gaps, SPI waits and the reset pulse.
module cmd_timeout_counter #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    input  logic [W-1:0] terminal,
    output logic         hit
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign hit = (count_reg == terminal);

endmodule

// File: rtl/uart_spi_cmd_bridge.sv
// Decodes framed commands from the UART byte stream, runs SPI register
// transactions and answers each frame with a single status/read-data byte.
module uart_spi_cmd_bridge
    import cmd_pkg::*;
#(
    parameter int         BYTE_TIMEOUT = 69440,
    parameter int         SPI_TIMEOUT  = 4096,
    parameter int         RESET_CYCLES = 16,
    parameter logic [7:0] READ_FLAG    = 8'h80,
    parameter int         TO_W         = 17
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_active,
    input  logic       i_tx_done,
    output logic       o_spi_start,
    output logic [7:0] o_spi_upper,
    output logic [7:0] o_spi_lower,
    input  logic       i_spi_busy,
    input  logic       i_spi_done,
    input  logic [7:0] i_spi_rx,
    output logic       o_soft_reset,
    output logic       o_busy,
    output logic       o_overrun
);

    state_t          state_reg, state_next;
    logic [7:0]      reply_reg, reply_next;
    logic [7:0]      upper_reg, upper_next;
    logic [7:0]      lower_reg, lower_next;
    logic [7:0]      addr_reg, addr_next;
    logic            is_read_reg, is_read_next;
    logic            byte_accept;
    logic            timer_clear, timer_enable, timer_hit;
    logic [TO_W-1:0] timer_terminal;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg   <= ST_IDLE;
            reply_reg   <= '0;
            upper_reg   <= '0;
            lower_reg   <= '0;
            addr_reg    <= '0;
            is_read_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            reply_reg   <= reply_next;
            upper_reg   <= upper_next;
            lower_reg   <= lower_next;
            addr_reg    <= addr_next;
            is_read_reg <= is_read_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        reply_next   = reply_reg;
        upper_next   = upper_reg;
        lower_next   = lower_reg;
        addr_next    = addr_reg;
        is_read_next = is_read_reg;
        byte_accept  = 1'b0;
        o_spi_start  = 1'b0;
        o_tx_dv      = 1'b0;
        o_soft_reset = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (i_rx_dv) begin
                    unique case (i_rx_byte)
                        OP_WRITE: begin is_read_next = 1'b0; state_next = ST_GET_ADDR; end
                        OP_READ:  begin is_read_next = 1'b1; state_next = ST_GET_ADDR; end
                        OP_RESET: state_next = ST_RST_HOLD;
                        OP_PING:  begin reply_next = RSP_OK;  state_next = ST_REPLY; end
                        default:  begin reply_next = RSP_UNK; state_next = ST_REPLY; end
                    endcase
                end
            end
            ST_GET_ADDR: begin
                if (i_rx_dv) begin
                    byte_accept = 1'b1;
                    addr_next   = i_rx_byte;
                    if (is_read_reg) begin
                        upper_next = i_rx_byte | READ_FLAG;
                        lower_next = 8'h00;
                        state_next = ST_SPI_ISSUE;
                    end else begin
                        state_next = ST_GET_DATA;
                    end
                end else if (timer_hit) begin
                    reply_next = RSP_TIMEOUT;
                    state_next = ST_REPLY;
                end
            end
            ST_GET_DATA: begin
                if (i_rx_dv) begin
                    byte_accept = 1'b1;
                    upper_next  = addr_reg;
                    lower_next  = i_rx_byte;
                    state_next  = ST_SPI_ISSUE;
                end else if (timer_hit) begin
                    reply_next = RSP_TIMEOUT;
                    state_next = ST_REPLY;
                end
            end
            ST_SPI_ISSUE: begin
                if (!i_spi_busy) begin
                    o_spi_start = 1'b1;
                    state_next  = ST_SPI_WAIT;
                end else if (timer_hit) begin
                    reply_next = RSP_SPIERR;
                    state_next = ST_REPLY;
                end
            end
            ST_SPI_WAIT: begin
                if (i_spi_done) begin
                    reply_next = is_read_reg ? i_spi_rx : RSP_OK;
                    state_next = ST_REPLY;
                end else if (timer_hit) begin
                    reply_next = RSP_SPIERR;
                    state_next = ST_REPLY;
                end
            end
            ST_RST_HOLD: begin
                o_soft_reset = 1'b1;
                if (timer_hit) begin
                    reply_next = RSP_OK;
                    state_next = ST_REPLY;
                end
            end
            ST_REPLY: begin
                if (!i_tx_active) begin
                    o_tx_dv    = 1'b1;
                    state_next = ST_REPLY_WAIT;
                end
            end
            ST_REPLY_WAIT: begin
                if (i_tx_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Terminal is count-1 because the counter reads 0 on the first cycle in a state.
    always_comb begin
        timer_terminal = '0;
        unique case (state_reg)
            ST_GET_ADDR, ST_GET_DATA:  timer_terminal = TO_W'(BYTE_TIMEOUT - 1);
            ST_SPI_ISSUE, ST_SPI_WAIT: timer_terminal = TO_W'(SPI_TIMEOUT - 1);
            ST_RST_HOLD:               timer_terminal = TO_W'(RESET_CYCLES - 1);
            default:                   timer_terminal = '0;
        endcase
    end

    assign timer_clear  = (state_next != state_reg) || byte_accept;
    assign timer_enable = state_reg inside {ST_GET_ADDR, ST_GET_DATA, ST_SPI_ISSUE,
                                            ST_SPI_WAIT, ST_RST_HOLD};

    cmd_timeout_counter #(
        .W (TO_W)
    ) u_timer (
        .clk        (i_clock),
        .srst       (i_reset),
        .clear      (timer_clear),
        .load       (1'b0),
        .load_value ({TO_W{1'b0}}),
        .enable     (timer_enable),
        .terminal   (timer_terminal),
        .hit        (timer_hit)
    );

    assign o_tx_byte   = reply_reg;
    assign o_spi_upper = upper_reg;
    assign o_spi_lower = lower_reg;
    assign o_busy      = (state_reg != ST_IDLE);
    assign o_overrun   = i_rx_dv && !(state_reg inside {ST_IDLE, ST_GET_ADDR, ST_GET_DATA});

endmodule
